neuron_mac: RTL and testbench

Single-neuron multiply-accumulate stage that sits directly upstream of the tanh activation unit. It consumes a stream of N_IN (activation, weight) pairs plus one bias per vector. It accumulates the signed products at full precision, then requantizes the sum to the signed Q2.6 pre-activation format the tanh stage expects. The result is presented as a one-cycle out_valid pulse with out_y, which maps directly onto the tanh stage's in_valid/in_x.

---
 rtl/neuron_mac.sv | 132 +++++++++++++
 tb/tb_neuron_mac.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Single-neuron MAC: accumulates N_IN signed Q1.7 x Q2.6 products plus a Q2.6 bias,
// then floor-requantizes the Q.13 sum to saturated Q2.6 for the downstream tanh stage.
module neuron_mac #(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned ACC_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [7:0] in_w,
  input  logic [7:0] in_bias,
  output logic [7:0] out_y,
  output logic       out_valid,
  output logic       busy
);

  localparam int unsigned CntW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N_IN - 1);

  typedef enum logic [1:0] {StIdle, StAcc, StFlush} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [15:0]        p_q, p_d;
  logic               p_valid_q, p_valid_d;
  logic [7:0]         out_y_q, out_y_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic signed [15:0] prod;
  logic [ACC_W-1:0]   p_ext;
  logic [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic               sat_pos, sat_neg;
  logic [7:0]         y_sat;

  assign in_ready = (state_q != StFlush);
  assign busy     = (state_q != StIdle);
  assign accept   = in_valid && in_ready;

  assign prod     = $signed(in_x) * $signed(in_w);
  assign p_ext    = {{(ACC_W-16){p_q[15]}}, p_q};
  // Bias is Q2.6; shift by 7 to line up with the Q.13 product grid.
  assign bias_ext = {{(ACC_W-15){in_bias[7]}}, in_bias, 7'b0};
  assign sum      = $signed(acc_q + p_ext);
  assign shifted  = sum >>> 7;

  // In range iff bits above bit 7 all equal the sign bit.
  assign sat_pos  = !shifted[ACC_W-1] && (|shifted[ACC_W-2:7]);
  assign sat_neg  = shifted[ACC_W-1] && !(&shifted[ACC_W-2:7]);

  always_comb begin
    y_sat = shifted[7:0];
    if (sat_pos) begin
      y_sat = 8'h7F;
    end else if (sat_neg) begin
      y_sat = 8'h80;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    p_d         = p_q;
    p_valid_d   = accept;
    out_y_d     = out_y_q;
    out_valid_d = 1'b0;

    if (p_valid_q) begin
      acc_d = sum;
    end
    if (accept) begin
      p_d = prod;
    end

    unique case (state_q)
      StIdle: begin
        // p_valid_q is never set here: nothing is accepted in the preceding FLUSH cycle.
        if (accept) begin
          acc_d   = bias_ext;
          cnt_d   = CntW'(1);
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (accept) begin
          if (cnt_q == CntLast) begin
            state_d = StFlush;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StFlush: begin
        out_y_d     = y_sat;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      p_valid_q   <= 1'b0;
      out_y_q     <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      p_valid_q   <= p_valid_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_y     = out_y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: arithmetic, saturation, floor rounding, handshake,
// back-to-back throughput and mid-vector reset, checked with immediate assertions.
module tb_neuron_mac;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [7:0] in_w;
  logic [7:0] in_bias;
  logic [7:0] out_y;
  logic       out_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stalls = 0;
  int pulses = 0;
  int pulse_cyc[$];
  logic [7:0] pulse_y[$];

  neuron_mac #(.N_IN(16), .ACC_W(24)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_bias   (in_bias),
    .out_y     (out_y),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      pulses <= pulses + 1;
      pulse_cyc.push_back(cyc);
      pulse_y.push_back(out_y);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one beat at a negedge and returns at the negedge after it was accepted.
  task automatic beat(input logic [7:0] x, input logic [7:0] w, input logic [7:0] b);
    int guard = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_w     = w;
    in_bias  = b;
    while (in_ready !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
      stalls++;
    end
    if (in_ready !== 1'b1) chk("beat_accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_x     = 8'($urandom);
    in_w     = 8'($urandom);
    in_bias  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic vec(input logic [7:0] x1, input logic [7:0] w1, input logic [7:0] xr,
                     input logic [7:0] wr, input logic [7:0] b, input bit gaps);
    beat(x1, w1, b);
    for (int i = 1; i < 16; i++) begin
      if (gaps) idle(int'($urandom_range(0, 3)));
      beat(xr, wr, b);
    end
  endtask

  // Called at the negedge after beat 16 is accepted: FLUSH now, pulse next cycle.
  task automatic expect_result(input string tag, input logic [7:0] exp);
    chk({tag, "_flush_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_flush_busy"}, 32'(busy), 32'd1);
    chk({tag, "_flush_nvalid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_y"}, 32'(out_y), 32'(exp));
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(out_valid), 32'd0);
    chk({tag, "_y_hold"}, 32'(out_y), 32'(exp));
  endtask

  initial begin
    int n0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_x     = 8'h00;
    in_w     = 8'h00;
    in_bias  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_out_y", 32'(out_y), 32'h00);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    idle(2);

    // 16 * (0.0625 * 1.0) = 1.0
    vec(8'h08, 8'h40, 8'h08, 8'h40, 8'h00, 1'b0);
    expect_result("basic", 8'h40);
    // Same with bias -0.5
    vec(8'h08, 8'h40, 8'h08, 8'h40, 8'hE0, 1'b0);
    expect_result("bias_neg", 8'h20);
    vec(8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 1'b0);
    expect_result("sat_pos", 8'h7F);
    vec(8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 1'b0);
    expect_result("sat_neg", 8'h80);
    // Sum of -1 LSB of Q.13 must floor to -1 LSB of Q2.6
    vec(8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
    expect_result("floor", 8'hFF);
    vec(8'h08, 8'h40, 8'h08, 8'h40, 8'h00, 1'b1);
    expect_result("gaps", 8'h40);
    idle(3);

    // Back-to-back with in_valid held through FLUSH; second vector carries its own bias
    n0     = pulse_cyc.size();
    stalls = 0;
    vec(8'h08, 8'h40, 8'h08, 8'h40, 8'h00, 1'b0);
    vec(8'h08, 8'h40, 8'h08, 8'h40, 8'hE0, 1'b0);
    chk("b2b_stall_cycles", 32'(stalls), 32'd1);
    idle(4);
    chk("b2b_pulse_count", 32'(pulse_cyc.size() - n0), 32'd2);
    if (pulse_cyc.size() >= n0 + 2) begin
      chk("b2b_y0", 32'(pulse_y[n0]), 32'h40);
      chk("b2b_y1", 32'(pulse_y[n0+1]), 32'h20);
      chk("b2b_period", 32'(pulse_cyc[n0+1] - pulse_cyc[n0]), 32'd17);
    end

    // Reset after 7 beats discards the partial vector
    for (int i = 0; i < 7; i++) beat(8'h08, 8'h40, 8'h00);
    n0    = pulses;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_y", 32'(out_y), 32'h00);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    chk("mid_rst_no_pulse", 32'(pulses), 32'(n0));
    vec(8'h08, 8'h40, 8'h08, 8'h40, 8'h00, 1'b0);
    expect_result("after_rst", 8'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
